// File: rtl/note_tone_synth.sv
// Note-code consumer: registers the 4-bit note bus, holds the note through a
// programmable release time, and drives a 16-bit phase-accumulator square wave.
module note_tone_synth #(
  parameter int unsigned SUSTAIN_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] note_in,
  input  logic       mute,
  output logic       wave_out,
  output logic       active,
  output logic [3:0] note_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [15:0] REL_INIT =
    (SUSTAIN_CYCLES != 0) ? 16'(SUSTAIN_CYCLES - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [3:0]  note_q, note_d;
  logic [3:0]  cur_note_q, cur_note_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] rel_cnt_q, rel_cnt_d;

  // Phase increment per 10 kHz tick: round(f * 65536 / 10000).
  function automatic logic [15:0] inc_of(input logic [3:0] n);
    case (n)
      4'd1:    inc_of = 16'd1715;
      4'd2:    inc_of = 16'd1817;
      4'd3:    inc_of = 16'd1925;
      4'd4:    inc_of = 16'd2039;
      4'd5:    inc_of = 16'd2160;
      4'd6:    inc_of = 16'd2289;
      4'd7:    inc_of = 16'd2425;
      4'd8:    inc_of = 16'd2569;
      4'd9:    inc_of = 16'd2722;
      4'd10:   inc_of = 16'd2884;
      4'd11:   inc_of = 16'd3055;
      4'd12:   inc_of = 16'd3237;
      4'd13:   inc_of = 16'd3429;
      default: inc_of = 16'd0;
    endcase
  endfunction

  // Invalid codes 14/15 are folded to "off" so the FSM never sees them.
  assign note_d = (note_in > 4'd13) ? 4'd0 : note_in;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    cur_note_d = cur_note_q;
    rel_cnt_d  = rel_cnt_q;
    acc_d      = (state_q != IDLE) ? acc_q + inc_of(cur_note_q) : 16'd0;

    if (mute) begin
      state_d    = IDLE;
      cur_note_d = 4'd0;
      rel_cnt_d  = 16'd0;
      acc_d      = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (note_q != 4'd0) begin
            state_d    = PLAY;
            cur_note_d = note_q;
          end
        end
        PLAY: begin
          if (note_q != 4'd0) begin
            cur_note_d = note_q;
          end else if (SUSTAIN_CYCLES != 0) begin
            state_d   = RELEASE;
            rel_cnt_d = REL_INIT;
          end else begin
            state_d    = IDLE;
            cur_note_d = 4'd0;
            acc_d      = 16'd0;
          end
        end
        RELEASE: begin
          // A retrigger outranks the release timeout in the same cycle.
          if (note_q != 4'd0) begin
            state_d    = PLAY;
            cur_note_d = note_q;
            rel_cnt_d  = 16'd0;
          end else if (rel_cnt_q == 16'd0) begin
            state_d    = IDLE;
            cur_note_d = 4'd0;
            acc_d      = 16'd0;
          end else begin
            rel_cnt_d = rel_cnt_q - 16'd1;
          end
        end
        default: begin
          state_d    = IDLE;
          cur_note_d = 4'd0;
          rel_cnt_d  = 16'd0;
          acc_d      = 16'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      note_q     <= 4'd0;
      cur_note_q <= 4'd0;
      acc_q      <= 16'd0;
      rel_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      cur_note_q <= cur_note_d;
      acc_q      <= acc_d;
      rel_cnt_q  <= rel_cnt_d;
    end
  end

  assign wave_out = acc_q[15];
  assign active   = (state_q != IDLE);
  assign note_out = cur_note_q;

endmodule

// File: tb/tb_note_tone_synth.sv
// Directed bench for note_tone_synth: reset, latency, glitch-free pitch changes,
// release timing for two sustain settings, retrigger, mute, invalid codes, pitch.
module tb_note_tone_synth;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic       mute = 1'b0;
  logic       wave_out, active;
  logic [3:0] note_out;
  logic       wave0, active0;
  logic [3:0] note_out0;

  int n_checks = 0;
  int n_errors = 0;

  note_tone_synth #(.SUSTAIN_CYCLES(2500)) dut (
    .clk(clk), .n_rst(n_rst), .note_in(note_in), .mute(mute),
    .wave_out(wave_out), .active(active), .note_out(note_out)
  );

  note_tone_synth #(.SUSTAIN_CYCLES(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .note_in(note_in), .mute(mute),
    .wave_out(wave0), .active(active0), .note_out(note_out0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int rises, bad;
  logic prev_wave;

  initial begin
    // Reset state
    #12;
    check("rst_wave", wave_out, 0);
    check("rst_active", active, 0);
    check("rst_note", note_out, 0);
    check("rst_acc", dut.acc_q, 0);
    #5 n_rst = 1'b1;
    tick(1);

    // Invalid code 14 from IDLE is treated as off
    note_in = 4'd14;
    tick(3);
    check("inv_active", active, 0);
    check("inv_note", note_out, 0);

    // Latency: edge k registers, k+1 enters PLAY, k+2 first increment
    note_in = 4'd1;
    tick(1);
    check("lat_k_active", active, 0);
    tick(1);
    check("lat_k1_active", active, 1);
    check("lat_k1_note", note_out, 1);
    check("lat_k1_acc", dut.acc_q, 0);
    tick(1);
    check("lat_k2_acc", dut.acc_q, 1715);
    tick(18);
    check("lat_19inc_acc", dut.acc_q, 32585);
    check("lat_19inc_wave", wave_out, 0);
    tick(1);
    check("lat_20inc_acc", dut.acc_q, 34300);
    check("lat_20inc_wave", wave_out, 1);

    // Pitch changes 1->3->8 keep the phase continuous
    note_in = 4'd3;
    tick(1);
    check("chg3_reg_acc", dut.acc_q, 36015);
    tick(1);
    check("chg3_note", note_out, 3);
    check("chg3_acc", dut.acc_q, 37730);
    tick(1);
    check("chg3_newinc", dut.acc_q, 39655);
    note_in = 4'd8;
    tick(2);
    check("chg8_note", note_out, 8);
    check("chg8_acc", dut.acc_q, 43505);
    tick(1);
    check("chg8_newinc", dut.acc_q, 46074);

    // Release timing: sustain 2500 vs sustain 0
    note_in = 4'd5;
    tick(3);
    check("rel_note5", note_out, 5);
    note_in = 4'd0;
    tick(1);
    check("rel_e_active", active, 1);
    check("rel0_e_active", active0, 1);
    tick(1);
    check("rel0_e1_active", active0, 0);
    check("rel0_e1_acc", dut0.acc_q, 0);
    check("rel0_e1_note", note_out0, 0);
    check("rel_e1_cnt", dut.rel_cnt_q, 2499);
    tick(2499);
    check("rel_last_active", active, 1);
    check("rel_last_note", note_out, 5);
    tick(1);
    check("rel_done_active", active, 0);
    check("rel_done_acc", dut.acc_q, 0);
    check("rel_done_note", note_out, 0);

    // Retrigger with note 13 while rel_cnt = 1000; phase carried over
    note_in = 4'd5;
    tick(3);
    check("rt_acc_first", dut.acc_q, 2160);
    note_in = 4'd0;
    tick(2);
    check("rt_acc_relentry", dut.acc_q, 6480);
    tick(1499);
    check("rt_cnt1000", dut.rel_cnt_q, 1000);
    check("rt_acc_at1000", dut.acc_q, 33056);
    note_in = 4'd13;
    tick(1);
    check("rt_reg_acc", dut.acc_q, 35216);
    check("rt_reg_active", active, 1);
    tick(1);
    check("rt_note", note_out, 13);
    check("rt_acc", dut.acc_q, 37376);
    tick(1);
    check("rt_newinc", dut.acc_q, 40805);

    // Mute during RELEASE with simultaneous note 7
    note_in = 4'd0;
    tick(2);
    check("mute_pre_cnt", dut.rel_cnt_q, 2499);
    note_in = 4'd7;
    mute = 1'b1;
    tick(1);
    check("mute_active", active, 0);
    check("mute_wave", wave_out, 0);
    check("mute_note", note_out, 0);
    check("mute_acc", dut.acc_q, 0);
    note_in = 4'd0;
    tick(1);
    mute = 1'b0;
    tick(2);
    check("mute_after_active", active, 0);

    // Pitch: note 10 for 10000 increments gives 440 rising edges
    note_in = 4'd10;
    tick(2);
    check("pitch_start_acc", dut.acc_q, 0);
    rises = 0;
    bad = 0;
    prev_wave = wave_out;
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      if (wave_out && !prev_wave) rises++;
      if (note_out !== 4'd10 || active !== 1'b1) bad++;
      prev_wave = wave_out;
    end
    check("pitch_rises", rises, 440);
    check("pitch_hold", bad, 0);

    // Asynchronous reset mid-tone
    #3 n_rst = 1'b0;
    #1;
    check("arst_active", active, 0);
    check("arst_note", note_out, 0);
    check("arst_wave", wave_out, 0);
    check("arst_acc", dut.acc_q, 0);
    note_in = 4'd0;
    #2 n_rst = 1'b1;
    tick(3);
    check("arst_idle_active", active, 0);
    check("arst_idle_note", note_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
